// File: rtl/glm_sbox_compress_if.sv
// Handshake bundle between the GLM term generators, the compression stage and the linear layer.
interface glm_sbox_compress_if #(
  parameter int NUM_DOMAINS = 16,
  parameter int NIBBLE_W    = 4
);
  logic                                in_valid;
  logic                                in_ready;
  logic [NUM_DOMAINS*NIBBLE_W-1:0]     domain_in;
  logic [(NUM_DOMAINS/2)*NIBBLE_W-1:0] rand_in;
  logic                                out_valid;
  logic                                out_ready;
  logic [NIBBLE_W-1:0]                 share0;
  logic [NIBBLE_W-1:0]                 share1;

  modport master (
    output in_valid, domain_in, rand_in, out_ready,
    input  in_ready, out_valid, share0, share1
  );

  modport slave (
    input  in_valid, domain_in, rand_in, out_ready,
    output in_ready, out_valid, share0, share1
  );
endinterface

// File: rtl/glm_sbox_compress.sv
// Masked PRINCE S-box compression: per-domain refresh register (glitch barrier), then XOR into two shares.
// PRINCE_SBOX_REFRESH_EN: when defined, rand_in masks are applied; otherwise rand_in is ignored (debug only).
module glm_sbox_compress #(
  parameter int NUM_DOMAINS = 16,
  parameter int NIBBLE_W    = 4
) (
  input logic              clk,
  input logic              rst,
  glm_sbox_compress_if.slave bus
);
  localparam int HALF = NUM_DOMAINS / 2;

  logic                v1;
  logic                out_valid_q;
  logic [NIBBLE_W-1:0] share0_q;
  logic [NIBBLE_W-1:0] share1_q;
  logic [NIBBLE_W-1:0] r1   [NUM_DOMAINS];
  logic [NIBBLE_W-1:0] r1_d [NUM_DOMAINS];
  logic [NIBBLE_W-1:0] xor0;
  logic [NIBBLE_W-1:0] xor1;
  logic                stall1;
  logic                stall2;
  logic                load1;

  assign stall2 = out_valid_q & ~bus.out_ready;
  assign stall1 = v1 & stall2;
  assign load1  = bus.in_valid & ~stall1;

  assign bus.in_ready  = ~stall1;
  assign bus.out_valid = out_valid_q;
  assign bus.share0    = share0_q;
  assign bus.share1    = share1_q;

  // Mask j is shared by domain j and its partner j+HALF, so it cancels in share0^share1.
`ifdef PRINCE_SBOX_REFRESH_EN
  always_comb begin
    for (int i = 0; i < NUM_DOMAINS; i++) r1_d[i] = '0;
    for (int i = 0; i < HALF; i++) begin
      r1_d[i]      = bus.domain_in[i*NIBBLE_W +: NIBBLE_W] ^ bus.rand_in[i*NIBBLE_W +: NIBBLE_W];
      r1_d[i+HALF] = bus.domain_in[(i+HALF)*NIBBLE_W +: NIBBLE_W] ^ bus.rand_in[i*NIBBLE_W +: NIBBLE_W];
    end
  end
`else
  logic unused_rand;
  assign unused_rand = ^bus.rand_in;

  always_comb begin
    for (int i = 0; i < NUM_DOMAINS; i++) r1_d[i] = bus.domain_in[i*NIBBLE_W +: NIBBLE_W];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      for (int i = 0; i < NUM_DOMAINS; i++) r1[i] <= '0;
    end else if (load1) begin
      v1 <= 1'b1;
      for (int i = 0; i < NUM_DOMAINS; i++) r1[i] <= r1_d[i];
    end else if (!stall1) begin
      v1 <= 1'b0;
    end
  end

  // Compression reads only registered domains so no glitch can combine unmasked terms.
  always_comb begin
    xor0 = '0;
    xor1 = '0;
    for (int i = 0; i < HALF; i++) begin
      xor0 = xor0 ^ r1[i];
      xor1 = xor1 ^ r1[i+HALF];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      share0_q    <= '0;
      share1_q    <= '0;
    end else if (!stall2) begin
      out_valid_q <= v1;
      if (v1) begin
        share0_q <= xor0;
        share1_q <= xor1;
      end
    end
  end
endmodule
